// File: rtl/event_encoder8to3_if.sv
// Bus bundle for the event encoder: capture inputs, the index handshake
// and the debug/status outputs. master = encoder side, slave = its user.
interface event_encoder8to3_if;
  logic       en;
  logic [7:0] D;
  logic [2:0] a;
  logic       valid;
  logic       ready;
  logic [7:0] pend;
  logic       ovf;

  modport master (
    input  en, D, ready,
    output a, valid, pend, ovf
  );

  modport slave (
    output en, D, ready,
    input  a, valid, pend, ovf
  );
endinterface

// File: rtl/event_encoder8to3.sv
// Sequential 8-to-3 event encoder. Event pulses on eight lines are latched
// into a pending register and handed out one index per handshake, highest
// index first. Inverse of the 3-to-8 select decoder on the receive side.

// One pending bit: new event (set) wins over an accept (clr) on the same
// cycle; merge flags an event landing on a bit that is still pending.
module event_encoder8to3_pend_cell (
  input  logic clk,
  input  logic rst,
  input  logic set_i,
  input  logic clr_i,
  output logic q_o,
  output logic merge_o
);
  logic q_q, q_d;

  // next pending value and merge detect
  always_comb begin
    q_d     = (q_q & ~clr_i) | set_i;
    merge_o = set_i & q_q & ~clr_i;
  end

  // pending bit register
  always_ff @(posedge clk) begin
    if (rst) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  assign q_o = q_q;
endmodule

module event_encoder8to3 (
  input logic                  clk,
  input logic                  rst,
  event_encoder8to3_if.master  bus
);
  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [2:0] a_q, a_d;
  logic       ovf_q, ovf_d;
  logic [7:0] pend_q;
  logic [7:0] merge;
  logic [7:0] set;
  logic [7:0] clr;
  logic [7:0] sel_src;
  logic       hs;

  // Highest set bit; 0 when empty (callers only use it when non-empty).
  function automatic logic [2:0] hi_idx(input logic [7:0] v);
    hi_idx = 3'd0;
    for (int i = 0; i < 8; i++)
      if (v[i]) hi_idx = 3'(i);
  endfunction

  // capture/accept masks; accept uses only registered a/valid
  always_comb begin
    hs      = (state_q == PRESENT) && bus.ready;
    set     = bus.D & {8{bus.en}};
    clr     = hs ? 8'(8'h01 << a_q) : 8'h00;
    // events arriving this cycle are not eligible for selection yet
    sel_src = pend_q & ~clr;
  end

  event_encoder8to3_pend_cell u_cell [7:0] (
    .clk     (clk),
    .rst     (rst),
    .set_i   (set),
    .clr_i   (clr),
    .q_o     (pend_q),
    .merge_o (merge)
  );

  // sticky overflow
  always_comb begin
    ovf_d = ovf_q | (|merge);
  end

  // next state / index: present highest pending, no preemption while held
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    case (state_q)
      IDLE: begin
        if (pend_q != 8'h00) begin
          a_d     = hi_idx(pend_q);
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (bus.ready) begin
          if (sel_src != 8'h00) a_d     = hi_idx(sel_src);
          else                  state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state, index and overflow registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= 3'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.a     = a_q;
  assign bus.valid = (state_q == PRESENT);
  assign bus.pend  = pend_q;
  assign bus.ovf   = ovf_q;
endmodule
